if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 160 ++++++++++++++++
 tb/tb_if_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches, tracks in-flight requests,
// buffers up to two returned instructions and squashes stale responses on redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [1:0]  out_q, out_d;
  logic [1:0]  drop_q, drop_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] b0_pc_q, b0_pc_d, b0_inst_q, b0_inst_d;
  logic [31:0] b1_pc_q, b1_pc_d, b1_inst_q, b1_inst_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;

  logic        xfer_s, resp_s, drop_s, push_s, pop_s;
  logic [31:0] resp_pc_s;
  logic [1:0]  unused_baddr_lsb;

  assign unused_baddr_lsb = branch_addr_i[1:0];

  // Next-state computation for fetch counter, tracking counters, buffer and FSM
  always_comb begin
    xfer_s    = req_q & imem_gnt_i;
    resp_s    = imem_rvalid_i & (out_q != 2'd0);
    drop_s    = resp_s & (drop_q != 2'd0);
    push_s    = resp_s & ~drop_s & ~branch_flag_i;
    pop_s     = (cnt_q != 2'd0) & ~stall_i;
    // Responses are in order and every live one postdates the last redirect,
    // so the oldest outstanding request sits out_q words behind fpc.
    resp_pc_s = fpc_q - {28'd0, out_q, 2'b00};

    state_d   = state_q;
    fpc_d     = fpc_q;
    out_d     = out_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    b0_pc_d   = b0_pc_q;
    b0_inst_d = b0_inst_q;
    b1_pc_d   = b1_pc_q;
    b1_inst_d = b1_inst_q;

    case ({xfer_s, resp_s})
      2'b10:   out_d = out_q + 2'd1;
      2'b01:   out_d = out_q - 2'd1;
      default: out_d = out_q;
    endcase

    if (branch_flag_i) begin
      fpc_d   = {branch_addr_i[31:2], 2'b00};
      drop_d  = out_d;
      state_d = (out_d != 2'd0) ? FLUSH : RUN;
      cnt_d   = 2'd0;
    end else begin
      fpc_d  = xfer_s ? (fpc_q + 32'd4) : fpc_q;
      drop_d = drop_s ? (drop_q - 2'd1) : drop_q;
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = RUN;
        FLUSH:   state_d = (drop_d == 2'd0) ? RUN : FLUSH;
        default: state_d = BOOT;
      endcase
      case ({push_s, pop_s})
        2'b11: begin
          if (cnt_q == 2'd1) begin
            b0_pc_d   = resp_pc_s;
            b0_inst_d = imem_rdata_i;
          end else begin
            b0_pc_d   = b1_pc_q;
            b0_inst_d = b1_inst_q;
            b1_pc_d   = resp_pc_s;
            b1_inst_d = imem_rdata_i;
          end
        end
        2'b10: begin
          if (cnt_q == 2'd0) begin
            b0_pc_d   = resp_pc_s;
            b0_inst_d = imem_rdata_i;
            cnt_d     = 2'd1;
          end else if (cnt_q == 2'd1) begin
            b1_pc_d   = resp_pc_s;
            b1_inst_d = imem_rdata_i;
            cnt_d     = 2'd2;
          end else begin
            cnt_d = cnt_q;
          end
        end
        2'b01: begin
          b0_pc_d   = b1_pc_q;
          b0_inst_d = b1_inst_q;
          cnt_d     = cnt_q - 2'd1;
        end
        default: cnt_d = cnt_q;
      endcase
    end

    req_d   = (state_d == RUN) && (({1'b0, out_d} + {1'b0, cnt_d}) < MAX_OUT);
    valid_d = (cnt_d != 2'd0);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      fpc_q     <= RESET_PC;
      out_q     <= 2'd0;
      drop_q    <= 2'd0;
      cnt_q     <= 2'd0;
      b0_pc_q   <= 32'h0000_0000;
      b0_inst_q <= 32'h0000_0000;
      b1_pc_q   <= 32'h0000_0000;
      b1_inst_q <= 32'h0000_0000;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      b0_pc_q   <= b0_pc_d;
      b0_inst_q <= b0_inst_d;
      b1_pc_q   <= b1_pc_d;
      b1_inst_q <= b1_inst_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = fpc_q;
  assign pc_o         = b0_pc_q;
  assign inst_o       = b0_inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a queue-based reference model plus an
// in-order memory model, directed scenarios followed by randomized traffic.
module tb_if_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] WPC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, br = 1'b0, gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] baddr = 32'h0, rdata = 32'h0;
  logic        imem_req_o, inst_valid_o;
  logic [31:0] imem_addr_o, pc_o, inst_o;

  logic        w_rv = 1'b0;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_inst;

  if_stage #(.RESET_PC(RPC), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(br), .branch_addr_i(baddr),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
  );

  if_stage #(.RESET_PC(WPC), .MAX_OUTSTANDING(2)) dut_w (
    .clk(clk), .rst(rst), .stall_i(1'b0), .branch_flag_i(1'b0), .branch_addr_i(32'h0),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(1'b1),
    .imem_rvalid_i(w_rv), .imem_rdata_i(32'h0000_0013),
    .pc_o(w_pc), .inst_o(w_inst), .inst_valid_o(w_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0;
  int p_stall = 0, p_br = 0, p_gnt = 100, lat_max = 1;
  bit hold = 1'b0, spur = 1'b0;

  bit          hs_req, real_rv, pre_valid, w_hs, w_rv_next;
  logic [31:0] hs_addr, pre_pc, w_ha;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          last_due = 0;
  logic [31:0] pend_addr[$];
  bit          pend_stale[$];
  logic [31:0] bq_pc[$];
  logic [31:0] m_fpc = RPC;
  bit          m_req = 1'b0;
  logic [31:0] cons[$], hs_log[$], w_log[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chk_first(input string nm, input logic [31:0] q[$], input logic [31:0] exp);
    if (q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: no entry recorded, expected %h (cycle %0d)", nm, exp, cyc);
    end else begin
      chk(nm, q[0], exp);
    end
  endtask

  task automatic drive_rand();
    @(negedge clk);
    hs_req    = imem_req_o;
    hs_addr   = imem_addr_o;
    pre_valid = inst_valid_o;
    pre_pc    = pc_o;
    w_hs      = w_req;
    w_ha      = w_addr;
    w_rv      = w_rv_next;
    stall     = ($urandom_range(99) < p_stall);
    br        = ($urandom_range(99) < p_br);
    baddr     = $urandom;
    gnt       = ($urandom_range(99) < p_gnt);
    real_rv   = 1'b0;
    rvalid    = 1'b0;
    rdata     = $urandom;
    if (!hold && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      real_rv = 1'b1;
      rvalid  = 1'b1;
      rdata   = memf(mq_addr[0]);
    end else if (spur && mq_addr.size() == 0 && $urandom_range(99) < 3) begin
      rvalid = 1'b1;
    end
  endtask

  task automatic settle();
    bit xf, rs, ok, stale;
    logic [31:0] a;
    int due;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      mq_addr.delete(); mq_due.delete(); last_due = 0;
      pend_addr.delete(); pend_stale.delete(); bq_pc.delete();
      cons.delete(); w_log.delete();
      m_fpc = RPC; m_req = 1'b0; w_rv_next = 1'b0;
    end else begin
      if (real_rv) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (hs_req && gnt) begin
        due = cyc + int'($urandom_range(lat_max - 1, 0));
        if (due < last_due) due = last_due;
        last_due = due;
        mq_addr.push_back(hs_addr);
        mq_due.push_back(due);
        hs_log.push_back(hs_addr);
      end
      if (pre_valid && !stall) cons.push_back(pre_pc);
      if (w_hs && w_log.size() < 3) w_log.push_back(w_ha);
      w_rv_next = w_hs;

      // reference model: in-flight requests in order, stale ones squashed
      xf = m_req && gnt;
      rs = rvalid && (pend_addr.size() > 0);
      ok = 1'b0;
      a  = 32'h0;
      if (rs) begin
        a  = pend_addr.pop_front();
        ok = !pend_stale.pop_front() && !br;
      end
      if (xf) begin
        pend_addr.push_back(m_fpc);
        pend_stale.push_back(1'b0);
        m_fpc = m_fpc + 32'd4;
      end
      if (br) begin
        foreach (pend_stale[i]) pend_stale[i] = 1'b1;
        bq_pc.delete();
        m_fpc = {baddr[31:2], 2'b00};
      end else begin
        if (bq_pc.size() > 0 && !stall) void'(bq_pc.pop_front());
        if (ok) bq_pc.push_back(a);
      end
      stale = 1'b0;
      foreach (pend_stale[i]) if (pend_stale[i]) stale = 1'b1;
      m_req = !stale && ((pend_addr.size() + bq_pc.size()) < 2);
    end
    chk("req", {31'd0, imem_req_o}, {31'd0, m_req});
    chk("addr", imem_addr_o, m_fpc);
    chk("valid", {31'd0, inst_valid_o}, {31'd0, bq_pc.size() > 0});
    if (bq_pc.size() > 0) begin
      chk("pc", pc_o, bq_pc[0]);
      chk("inst", inst_o, memf(bq_pc[0]));
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      drive_rand();
      settle();
    end
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req_o}, 32'd0);
    chk({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
    chk({tag, "_pc"}, pc_o, 32'h0000_0000);
    chk({tag, "_inst"}, inst_o, 32'h0000_0000);
    chk({tag, "_addr"}, imem_addr_o, RPC);
  endtask

  initial begin
    bit hit;

    // reset and stream
    rst = 1'b1;
    steps(2);
    reset_literals("rst");
    drive_rand(); rst = 1'b0; settle();
    chk("first_req", {31'd0, imem_req_o}, 32'd1);
    chk("first_addr", imem_addr_o, 32'h0000_0000);
    steps(12);
    if (cons.size() < 4) begin
      n_chk++; n_err++;
      $display("FAIL stream_len: got %0d consumed, expected at least 4", cons.size());
    end else begin
      chk("stream0", cons[0], 32'h0000_0000);
      chk("stream1", cons[1], 32'h0000_0004);
      chk("stream2", cons[2], 32'h0000_0008);
      chk("stream3", cons[3], 32'h0000_000C);
    end
    if (w_log.size() < 3) begin
      n_chk++; n_err++;
      $display("FAIL wrap_len: got %0d requests, expected 3", w_log.size());
    end else begin
      chk("wrap0", w_log[0], 32'hFFFF_FFF8);
      chk("wrap1", w_log[1], 32'hFFFF_FFFC);
      chk("wrap2", w_log[2], 32'h0000_0000);
    end

    // stall with the buffer full
    p_stall = 100;
    steps(5);
    chk("stall_req", {31'd0, imem_req_o}, 32'd0);
    chk("stall_valid", {31'd0, inst_valid_o}, 32'd1);
    p_stall = 0;
    steps(8);
    for (int i = 1; i < cons.size(); i++) chk("stream_seq", cons[i], cons[0] + 32'(4 * i));

    // redirect with two fetches outstanding
    hold = 1'b1;
    steps(4);
    chk("out2_req", {31'd0, imem_req_o}, 32'd0);
    chk("out2_valid", {31'd0, inst_valid_o}, 32'd0);
    drive_rand(); br = 1'b1; baddr = 32'h0000_0103; settle();
    chk("redir_req", {31'd0, imem_req_o}, 32'd0);
    cons.delete(); hs_log.delete();
    hold = 1'b0;
    steps(10);
    chk_first("redir_addr", hs_log, 32'h0000_0100);
    chk_first("redir_pc", cons, 32'h0000_0100);

    // branch, stall, grant and response in one cycle
    p_stall = 50;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      drive_rand();
      if (hs_req && real_rv) begin
        br = 1'b1; stall = 1'b1; gnt = 1'b1; baddr = 32'h0000_0200;
        hit = 1'b1;
      end
      settle();
      if (hit) begin
        chk("simul_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("simul_req", {31'd0, imem_req_o}, 32'd0);
      end
    end
    if (!hit) begin
      n_chk++; n_err++;
      $display("FAIL simul_setup: got no req+rvalid cycle, expected one within 40 cycles");
    end
    p_stall = 0;
    steps(6);

    // reset while flushing
    hold = 1'b1;
    steps(4);
    drive_rand(); br = 1'b1; baddr = 32'h0000_0040; settle();
    chk("flush_req", {31'd0, imem_req_o}, 32'd0);
    drive_rand(); rst = 1'b1; settle();
    reset_literals("rstflush");
    hold = 1'b0;
    hs_log.delete();
    drive_rand(); rst = 1'b0; settle();
    chk("restart_req", {31'd0, imem_req_o}, 32'd1);
    steps(4);
    chk_first("restart_addr", hs_log, RPC);

    // randomized traffic
    p_stall = 30; p_br = 5; p_gnt = 70; lat_max = 3; spur = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drive_rand();
      rst = ($urandom_range(999) < 3);
      settle();
    end
    drive_rand(); rst = 1'b0; br = 1'b0; settle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
